// File: rtl/uart_rx_port.sv
// UART receiver with a two-register io port (DATA, STATUS) on the discus bus.
// The serial frame is 8N1, LSB first; every bit is sampled once, at its midpoint.
module uart_rx_port #(
  parameter int         CLKS_PER_BIT = 289,
  parameter logic [7:0] BASE         = 8'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       io_read,
  input  logic       io_write,
  input  logic [7:0] io_address,
  input  logic [7:0] io_D,
  output logic [7:0] io_Q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [15:0] FULL_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]  STATUS_ADDR = BASE + 8'd1;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  index_q, index_d;
  logic        sync1_q, sync1_d;
  logic        rx_s_q, rx_s_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        framing_err_q, framing_err_d;
  logic [7:0]  rd_data_q, rd_data_d;

  logic deliver;
  logic frame_err;
  logic expired;
  logic data_hit;
  logic status_hit;
  logic status_wr;

  // Only bits 1 and 2 of a STATUS write carry meaning.
  logic unused_io_d;
  assign unused_io_d = ^{io_D[7:3], io_D[0]};

  assign io_Q = rd_data_q;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    index_d       = index_q;
    sync1_d       = rxd;
    rx_s_d        = sync1_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = valid_q;
    overrun_d     = overrun_q;
    framing_err_d = framing_err_q;
    rd_data_d     = 8'h00;
    deliver       = 1'b0;
    frame_err     = 1'b0;
    expired       = (count_q == 16'd0);

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          count_d = HALF_RELOAD;
        end
      end
      S_START: begin
        if (expired) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            count_d = FULL_RELOAD;
            index_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          count_d = count_q - 16'd1;
        end
      end
      S_DATA: begin
        if (expired) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          count_d = FULL_RELOAD;
          if (index_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            index_d = index_q + 3'd1;
          end
        end else begin
          count_d = count_q - 16'd1;
        end
      end
      S_STOP: begin
        if (expired) begin
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = S_BREAK;
          end
        end else begin
          count_d = count_q - 16'd1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    data_hit   = io_read && (io_address == BASE);
    status_hit = io_read && (io_address == STATUS_ADDR);
    status_wr  = io_write && (io_address == STATUS_ADDR);

    if (data_hit) begin
      rd_data_d = data_q;
      valid_d   = 1'b0;
    end else if (status_hit) begin
      rd_data_d = {5'b0, framing_err_q, overrun_q, valid_q};
    end

    if (status_wr && io_D[1]) overrun_d = 1'b0;
    if (status_wr && io_D[2]) framing_err_d = 1'b0;

    // A DATA read on the delivery cycle frees the holding register, so no overrun.
    if (deliver) begin
      if (valid_q && !data_hit) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
    if (frame_err) framing_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= 16'd0;
      index_q       <= 3'd0;
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      shift_q       <= 8'h00;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      framing_err_q <= 1'b0;
      rd_data_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      index_q       <= index_d;
      sync1_q       <= sync1_d;
      rx_s_q        <= rx_s_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      framing_err_q <= framing_err_d;
      rd_data_q     <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// Scoreboard bench for uart_rx_port: directed frames plus random frames with io traffic.
// Expected read data comes from an event-level model of the register file.
module tb_uart_rx_port;

  localparam int         CPB        = 16;
  localparam logic [7:0] BASE       = 8'h08;
  localparam logic [7:0] STAT       = 8'h09;
  localparam int         FRAME_LEN  = 10 * CPB;
  // Two synchronizer flops, half a bit to the start midpoint, then nine bit periods to the stop sample.
  localparam int         DELIVER_AT = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       io_read = 1'b0;
  logic       io_write = 1'b0;
  logic [7:0] io_address = 8'h00;
  logic [7:0] io_D = 8'h00;
  logic [7:0] io_Q;

  int checks = 0;
  int passed = 0;

  logic [7:0] exp_q[$];

  logic [7:0] m_data;
  bit         m_valid;
  bit         m_ovr;
  bit         m_ferr;

  uart_rx_port #(.CLKS_PER_BIT(CPB), .BASE(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .io_read(io_read),
    .io_write(io_write),
    .io_address(io_address),
    .io_D(io_D),
    .io_Q(io_Q)
  );

  always #5 clk = ~clk;

  function automatic void checkOutput(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
  endfunction

  // Register-file model: a read happens before any frame event of the same cycle,
  // and a status-clear write happens before a flag-setting event of the same cycle.
  function automatic void model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endfunction

  function automatic void model_read(logic [7:0] addr);
    if (addr == BASE) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end else if (addr == STAT) begin
      exp_q.push_back({5'b0, m_ferr, m_ovr, m_valid});
    end else begin
      exp_q.push_back(8'h00);
    end
  endfunction

  function automatic void model_write(logic [7:0] addr, logic [7:0] d);
    if (addr == STAT) begin
      if (d[1]) m_ovr = 1'b0;
      if (d[2]) m_ferr = 1'b0;
    end
  endfunction

  function automatic void model_frame(logic [7:0] b, bit stop);
    if (!stop) m_ferr = 1'b1;
    else if (m_valid) m_ovr = 1'b1;
    else begin
      m_data  = b;
      m_valid = 1'b1;
    end
  endfunction

  // Drives one clock cycle of inputs, starting and ending on a falling edge.
  task automatic applyStimulus(input bit line, input bit rd, input bit wr,
                               input logic [7:0] addr, input logic [7:0] d);
    rxd        = line;
    io_read    = rd;
    io_write   = wr;
    io_address = addr;
    io_D       = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic io_cycle(input int kind, input logic [7:0] addr, input logic [7:0] d, input bit line);
    if (kind == 1) begin
      model_read(addr);
      applyStimulus(line, 1'b1, 1'b0, addr, 8'h00);
    end else if (kind == 2) begin
      model_write(addr, d);
      applyStimulus(line, 1'b0, 1'b1, addr, d);
    end else begin
      applyStimulus(line, 1'b0, 1'b0, 8'h00, 8'h00);
    end
  endtask

  task automatic idle(input int n, input bit line);
    for (int i = 0; i < n; i++) applyStimulus(line, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic rd(input logic [7:0] addr);
    io_cycle(1, addr, 8'h00, 1'b1);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] d);
    io_cycle(2, addr, d, 1'b1);
  endtask

  // One serial frame; an optional io operation is issued at cycle op_at (no later than the stop sample).
  task automatic send_frame(input logic [7:0] b, input bit stop, input int op_at,
                            input int op_kind, input logic [7:0] op_addr, input logic [7:0] op_d);
    bit line;
    int bit_no;
    for (int c = 0; c < FRAME_LEN; c++) begin
      bit_no = c / CPB;
      if (bit_no == 0) line = 1'b0;
      else if (bit_no == 9) line = stop;
      else line = b[bit_no-1];
      if (c == op_at) io_cycle(op_kind, op_addr, op_d, line);
      else applyStimulus(line, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    model_frame(b, stop);
  endtask

  task automatic frame(input logic [7:0] b);
    send_frame(b, 1'b1, -1, 0, 8'h00, 8'h00);
    idle(4, 1'b1);
  endtask

  // Monitor: every read accepted outside reset yields one io_Q value, compared on the next falling edge.
  initial begin
    bit         was_read;
    logic [7:0] addr;
    forever begin
      @(posedge clk);
      was_read = io_read && !reset;
      addr     = io_address;
      @(negedge clk);
      if (was_read) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_read: addr %02h got %02h, expected no read", addr, io_Q);
        end else begin
          checkOutput($sformatf("read_%02h", addr), io_Q, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] b;
    bit         stop;
    int         kind;
    int         sel;
    logic [7:0] addr;

    model_reset();
    @(negedge clk);
    // Strobes during reset must be ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, BASE, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, STAT, 8'hFF);
    applyStimulus(1'b1, 1'b1, 1'b0, STAT, 8'h00);
    checkOutput("reset_io_Q", io_Q, 8'h00);
    reset = 1'b0;
    idle(4, 1'b1);
    checkOutput("idle_io_Q", io_Q, 8'h00);
    rd(STAT);
    rd(BASE);

    $display("[TB] single frame 0x55");
    frame(8'h55);
    rd(STAT);
    rd(BASE);
    rd(STAT);
    rd(8'h0A);

    $display("[TB] overrun A3 then 3C");
    frame(8'hA3);
    frame(8'h3C);
    rd(STAT);
    rd(BASE);
    wr(STAT, 8'h02);
    rd(STAT);
    wr(BASE, 8'hEE);
    rd(BASE);

    $display("[TB] framing error and break");
    send_frame(8'h7E, 1'b0, -1, 0, 8'h00, 8'h00);
    idle(40, 1'b0);
    idle(4, 1'b1);
    rd(STAT);
    rd(BASE);
    wr(STAT, 8'h04);
    rd(STAT);
    send_frame(8'hC3, 1'b0, -1, 0, 8'h00, 8'h00);
    idle(20, 1'b0);
    io_cycle(2, STAT, 8'h04, 1'b0);
    idle(200, 1'b0);
    idle(4, 1'b1);
    rd(STAT);

    $display("[TB] glitch rejection");
    idle(6, 1'b0);
    idle(30, 1'b1);
    rd(STAT);
    frame(8'h11);
    rd(BASE);

    $display("[TB] reset mid-frame");
    for (int c = 0; c < FRAME_LEN; c++) begin
      reset = (c >= 4 * CPB + 8) && (c < 4 * CPB + 11);
      applyStimulus((c < CPB) ? 1'b0 : 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    reset = 1'b0;
    model_reset();
    idle(4, 1'b1);
    rd(STAT);
    frame(8'h0F);
    rd(BASE);

    $display("[TB] read and clear on the delivery cycle");
    frame(8'h21);
    send_frame(8'h9A, 1'b1, DELIVER_AT, 1, BASE, 8'h00);
    idle(4, 1'b1);
    rd(STAT);
    send_frame(8'h44, 1'b1, DELIVER_AT, 2, STAT, 8'h02);
    idle(4, 1'b1);
    rd(STAT);
    wr(STAT, 8'h02);
    rd(BASE);
    rd(STAT);

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 2);
      sel  = $urandom_range(0, 3);
      addr = (sel < 2) ? BASE : (sel == 2) ? STAT : 8'($urandom);
      send_frame(b, stop, $urandom_range(0, DELIVER_AT), kind, addr, 8'($urandom));
      if (!stop) idle($urandom_range(1, 30), 1'b0);
      idle($urandom_range(2, 6), 1'b1);
      for (int k = 0; k < 3; k++) begin
        sel = $urandom_range(0, 4);
        if (sel == 0) io_cycle(2, STAT, 8'($urandom), 1'b1);
        else if (sel == 1) rd(STAT);
        else if (sel == 2) rd(BASE);
        else io_cycle(0, 8'h00, 8'h00, 1'b1);
      end
    end
    rd(STAT);
    rd(BASE);

    idle(5, 1'b1);
    checkOutput("pending_reads", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_port.md
UART_RX_PORT -- requirements
Module: uart_rx_port

Interface
REQ-001 Parameter CLKS_PER_BIT, default 289, clk cycles per serial bit (115200 baud at the 33.33 MHz io clock); legal range 4..65535.
REQ-002 Parameter BASE, default 8'h08, io address of the data register; BASE[0] SHALL be 0.
REQ-003 clk  input  1  io clock; all logic on its rising edge; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rxd  input  1  asynchronous serial line; idles high.
REQ-006 io_read  input  1  discus memory_read strobe.
REQ-007 io_write  input  1  discus memory_write strobe.
REQ-008 io_address  input  8  discus memory_address.
REQ-009 io_D  input  8  discus write data.
REQ-010 io_Q  output  8  registered read data, ORed into the discus memory_Q path.

Function
REQ-011 rxd SHALL pass through a two-flop synchronizer; all receiver logic uses only the second flop (rx_s).
REQ-012 Register map: BASE = DATA (read-only); BASE+1 = STATUS {5'b0, framing_err, overrun, valid}; any other address does not select the block.
REQ-013 io_Q SHALL update one clk after the io_read cycle: the selected register value if io_read and the address hits, else 8'h00.
REQ-014 A read of DATA SHALL return the held byte and clear valid at the same edge; a read of DATA with valid=0 returns the stale byte and has no side effect.
REQ-015 A write to STATUS with io_D[1]=1 SHALL clear overrun, and with io_D[2]=1 SHALL clear framing_err; writes to DATA are ignored.
REQ-016 Receiver FSM states: IDLE, START, DATA, STOP, BREAK; one down-counter (16 bits) and one bit index (3 bits).
REQ-017 IDLE: rx_s=0 -> START, counter = CLKS_PER_BIT/2 - 1 (integer division).
REQ-018 START: at counter 0, sample rx_s: 0 -> DATA with counter = CLKS_PER_BIT-1 and index 0; 1 -> IDLE (glitch rejected, no flag).
REQ-019 DATA: at each counter expiry, shift rx_s in LSB-first and reload; after the 8th sample -> STOP with counter = CLKS_PER_BIT-1.
REQ-020 STOP: at counter expiry, rx_s=1 -> deliver the byte, go to IDLE; rx_s=0 -> set framing_err, discard the byte, go to BREAK.
REQ-021 BREAK: remain until rx_s=1, then go to IDLE.
REQ-022 Delivery with valid=0: load DATA, set valid. Delivery with valid=1: set overrun, keep the old byte, discard the new one.
REQ-023 Delivery in the same cycle as a DATA read that clears valid: the read returns the old byte, the new byte is loaded, valid stays 1, no overrun.
REQ-024 Status-clear write in the same cycle as the event that sets the same flag: the flag SHALL end up set (set wins).
REQ-025 Bit timing: the start bit is sampled at its midpoint; each subsequent sample is exactly CLKS_PER_BIT clocks after the previous one, with no resynchronisation within a frame.

Reset
REQ-026 While reset is high: FSM = IDLE, counter and index = 0, both synchronizer flops = 1, shift and DATA registers = 0, valid, overrun and framing_err = 0, io_Q = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no flag and no delivery; after release, reception resumes at the next falling edge of rx_s.
REQ-028 While reset is high, io strobes SHALL be ignored.

Verification (CLKS_PER_BIT=16, BASE=8'h08)
REQ-029 Frame 0x55 with stop bit = 1, then read 0x09 and read 0x08 -> io_Q = 8'h01, then 8'h55; a following read of 0x09 -> 8'h00.
REQ-030 Two frames 0xA3 then 0x3C with no read in between -> read 0x09 = 8'h03, read 0x08 = 8'hA3; write 0x09 with 8'h02 -> STATUS = 8'h00.
REQ-031 Frame 0x7E with stop bit = 0, line held low for 40 clks then released -> STATUS = 8'h04, valid = 0, FSM returns to IDLE only after rxd goes high.
REQ-032 rxd low pulse of 6 clks -> no delivery, STATUS = 8'h00; a valid 0x11 frame that follows -> DATA = 8'h11.
REQ-033 Reset pulsed during bit 4 of frame 0xFF -> STATUS = 8'h00; the next frame 0x0F is received correctly.
REQ-034 A DATA read issued on the exact cycle the next byte is delivered -> io_Q = old byte, valid stays 1, overrun = 0, next DATA read = new byte.
